// File: rtl/freq_ctrl_sync.sv
// rtl/freq_ctrl_sync.sv - pin-side frequency/waveform qualifier with safe-point commit
module freq_ctrl_sync #(
  parameter int                    FREQ_WIDTH    = 13,
  parameter int                    SEL_WIDTH     = 2,
  parameter int                    STABLE_CYCLES = 1024,
  parameter int                    CNT_WIDTH     = 11,
  parameter logic [FREQ_WIDTH-1:0] FREQ_MAX      = 13'h1FFF,
  parameter logic [FREQ_WIDTH-1:0] FREQ_RESET    = 13'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FREQ_WIDTH-1:0] freq_pin,
  input  logic [SEL_WIDTH-1:0]  sel_pin,
  input  logic                  sync_point,
  output logic [FREQ_WIDTH-1:0] freq,
  output logic [SEL_WIDTH-1:0]  waveform_sel,
  output logic                  update,
  output logic                  pending
);

  localparam int W = FREQ_WIDTH + SEL_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TARGET = CNT_WIDTH'(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT    = '1;
  localparam logic [W-1:0]         C_RESET    = {FREQ_RESET, {SEL_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, SETTLE, ARMED} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          sync1_q, sync2_q;
  logic [W-1:0]          c_q, c_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [FREQ_WIDTH-1:0] freq_d;
  logic [SEL_WIDTH-1:0]  sel_d;
  logic                  update_d;
  logic [FREQ_WIDTH-1:0] c_freq, c_clamped;
  logic [SEL_WIDTH-1:0]  c_sel;
  logic                  changed, differs;

  // Both pin buses share one synchronizer so a half-toggled bus only looks like a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {freq_pin, sel_pin};
      sync2_q <= sync1_q;
    end
  end

  assign c_freq    = c_q[W-1:SEL_WIDTH];
  assign c_sel     = c_q[SEL_WIDTH-1:0];
  assign c_clamped = (c_freq > FREQ_MAX) ? FREQ_MAX : c_freq;
  assign changed   = (sync2_q != c_q);
  assign differs   = (c_clamped != freq) || (c_sel != waveform_sel);

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    freq_d   = freq;
    sel_d    = waveform_sel;
    update_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (changed) begin
          c_d     = sync2_q;
          cnt_d   = CNT_ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (changed) begin
          c_d   = sync2_q;
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_TARGET) begin
          state_d = differs ? ARMED : IDLE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ARMED: begin
        // Commit wins over a simultaneous input change; IDLE picks the change up next cycle.
        if (sync_point) begin
          freq_d   = c_clamped;
          sel_d    = c_sel;
          update_d = 1'b1;
          state_d  = IDLE;
        end else if (changed) begin
          c_d     = sync2_q;
          cnt_d   = CNT_ONE;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      c_q          <= C_RESET;
      cnt_q        <= '0;
      freq         <= FREQ_RESET;
      waveform_sel <= '0;
      update       <= 1'b0;
      pending      <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      cnt_q        <= cnt_d;
      freq         <= freq_d;
      waveform_sel <= sel_d;
      update       <= update_d;
      pending      <= (state_d == ARMED);
    end
  end

endmodule
